// File: rtl/register_access_sequencer_if.sv
// Request and register-bank signals of the register access sequencer.
// The sequencer side uses the slave modport; requester and bank use master.
interface register_access_sequencer_if;
   logic       start;
   logic [2:0] opcode;
   logic [2:0] reg_sel;
   logic [7:0] acc_in;
   logic       ready;
   logic       done;
   logic       err;
   logic [7:0] acc_out;
   logic       acc_we;
   logic       branch;
   logic       write_data;
   logic       read_data;
   logic [2:0] reg_in_select;
   logic [2:0] reg_out_select;
   logic [7:0] reg_in_data;
   logic [7:0] reg_out_data;

   modport master (
      output start, opcode, reg_sel, acc_in, reg_out_data,
      input  ready, done, err, acc_out, acc_we, branch,
      input  write_data, read_data, reg_in_select,
      input  reg_out_select, reg_in_data
   );

   modport slave (
      input  start, opcode, reg_sel, acc_in, reg_out_data,
      output ready, done, err, acc_out, acc_we, branch,
      output write_data, read_data, reg_in_select,
      output reg_out_select, reg_in_data
   );
endinterface

// File: rtl/register_access_sequencer.sv
// Sequences accumulator/register-bank operations (MOV, XCH, INC, DEC, DJNZ)
// as IDLE -> READ -> WRITE -> DONE over an 8-entry register bank.
module register_access_sequencer (
   input  logic                         clock,
   input  logic                         reset,
   register_access_sequencer_if.slave   bus
);
   localparam logic [2:0] OP_MOV_AR = 3'b000;
   localparam logic [2:0] OP_MOV_RA = 3'b001;
   localparam logic [2:0] OP_XCH    = 3'b010;
   localparam logic [2:0] OP_INC    = 3'b011;
   localparam logic [2:0] OP_DEC    = 3'b100;
   localparam logic [2:0] OP_DJNZ   = 3'b101;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t     state;
   logic [2:0] op_q;
   logic [2:0] sel_q;
   logic [7:0] acc_q;
   logic [7:0] temp;
   logic [7:0] temp_dec;

   assign bus.ready = (state == IDLE);
   assign temp_dec  = temp - 8'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         op_q               <= '0;
         sel_q              <= '0;
         acc_q              <= '0;
         temp               <= '0;
         bus.acc_out        <= '0;
         bus.branch         <= 1'b0;
         bus.done           <= 1'b0;
         bus.err            <= 1'b0;
         bus.acc_we         <= 1'b0;
         bus.read_data      <= 1'b0;
         bus.write_data     <= 1'b0;
         bus.reg_in_select  <= '0;
         bus.reg_out_select <= '0;
         bus.reg_in_data    <= '0;
      end else begin
         // Strobes and bank controls are valid for one state only
         bus.done           <= 1'b0;
         bus.err            <= 1'b0;
         bus.acc_we         <= 1'b0;
         bus.read_data      <= 1'b0;
         bus.write_data     <= 1'b0;
         bus.reg_in_select  <= '0;
         bus.reg_out_select <= '0;
         bus.reg_in_data    <= '0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q  <= bus.opcode;
                  sel_q <= bus.reg_sel;
                  acc_q <= bus.acc_in;
                  unique case (1'b1)
                     bus.opcode == OP_MOV_RA: begin
                        state             <= WRITE;
                        bus.write_data    <= 1'b1;
                        bus.reg_in_select <= bus.reg_sel;
                        bus.reg_in_data   <= bus.acc_in;
                     end
                     bus.opcode[2:1] == 2'b11: begin
                        state      <= DONE;
                        bus.done   <= 1'b1;
                        bus.err    <= 1'b1;
                        bus.branch <= 1'b0;
                     end
                     default: begin
                        state              <= READ;
                        bus.read_data      <= 1'b1;
                        bus.reg_out_select <= bus.reg_sel;
                     end
                  endcase
               end
            end
            READ: begin
               temp <= bus.reg_out_data;
               if (op_q == OP_MOV_AR) begin
                  state       <= DONE;
                  bus.done    <= 1'b1;
                  bus.acc_we  <= 1'b1;
                  bus.acc_out <= bus.reg_out_data;
                  bus.branch  <= 1'b0;
               end else begin
                  state             <= WRITE;
                  bus.write_data    <= 1'b1;
                  bus.reg_in_select <= sel_q;
                  unique case (1'b1)
                     op_q == OP_XCH: bus.reg_in_data <= acc_q;
                     op_q == OP_INC: bus.reg_in_data <= bus.reg_out_data + 8'd1;
                     default:        bus.reg_in_data <= bus.reg_out_data - 8'd1;
                  endcase
               end
            end
            WRITE: begin
               state      <= DONE;
               bus.done   <= 1'b1;
               bus.branch <= (op_q == OP_DJNZ) && (temp_dec != 8'd0);
               if (op_q == OP_XCH) begin
                  bus.acc_out <= temp;
                  bus.acc_we  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/register_access_sequencer.md
REGISTER_ACCESS_SEQUENCER -- requirements
Module: register_access_sequencer

Interface
REQ-001 SHALL have these ports, one clock domain; reset synchronous, active-high:
  clock  in  1  sole clock, all state updates on rising edge
  reset  in  1  synchronous active-high reset
  start  in  1  request strobe, accepted only while ready=1
  opcode  in  3  operation code (REQ-010)
  reg_sel  in  3  target register R0..R7
  acc_in  in  8  accumulator value supplied with request
  ready  out  1  high when idle and able to accept start
  done  out  1  one-cycle completion pulse
  err  out  1  high with done when opcode illegal
  acc_out  out  8  registered accumulator result
  acc_we  out  1  high with done when acc_out updated this op
  branch  out  1  DJNZ result, valid with done
  write_data  out  1  bank write enable
  read_data  out  1  bank read enable
  reg_in_select  out  3  bank write address
  reg_out_select  out  3  bank read address
  reg_in_data  out  8  bank write data
  reg_out_data  in  8  bank read data, combinational, valid same cycle as read_data
REQ-002 SHALL drive the bank ports of the downstream 8-entry register bank directly, with no other bank master.

Function
REQ-010 Opcodes SHALL be: 000 MOV A,Rn; 001 MOV Rn,A; 010 XCH A,Rn; 011 INC Rn; 100 DEC Rn; 101 DJNZ Rn; 110/111 illegal.
REQ-011 States SHALL be IDLE, READ, WRITE, DONE; ready = (state==IDLE), combinational.
REQ-012 On an edge with state IDLE and start=1, SHALL latch opcode, reg_sel, acc_in; start in any other state SHALL be ignored, no queuing.
REQ-013 Transitions from IDLE on accept: MOV A,Rn/XCH/INC/DEC/DJNZ -> READ; MOV Rn,A -> WRITE; illegal -> DONE.
REQ-014 READ: read_data=1, reg_out_select=latched reg_sel; reg_out_data captured into temp at cycle end; -> WRITE, except MOV A,Rn -> DONE.
REQ-015 WRITE: write_data=1, reg_in_select=latched reg_sel, reg_in_data = acc_in (MOV Rn,A, XCH), temp+1 (INC), temp-1 (DEC, DJNZ); -> DONE.
REQ-016 Arithmetic SHALL be 8-bit modulo-256: INC 8'hFF -> 8'h00, DEC/DJNZ 8'h00 -> 8'hFF; no flags besides branch.
REQ-017 DONE: done=1 for exactly one cycle; -> IDLE unconditionally.
REQ-018 acc_out SHALL update on entry to DONE to temp for MOV A,Rn and XCH, else hold; acc_we=1 in DONE only for those two ops.
REQ-019 branch SHALL be registered on entry to DONE as (temp-1 != 0) for DJNZ, 0 for all other ops; holds until next DONE entry.
REQ-020 err=1 only in DONE of an illegal op; illegal ops SHALL never assert read_data or write_data.
REQ-021 Outside READ, read_data=0 and reg_out_select=0; outside WRITE, write_data=0, reg_in_select=0, reg_in_data=0.
REQ-022 Latency from accepting edge to done high: 3 cycles XCH/INC/DEC/DJNZ, 2 cycles MOV A,Rn / MOV Rn,A, 1 cycle illegal; next start accepted earliest on the edge ending DONE+1 (ready high the cycle after DONE).
REQ-023 reg_sel, opcode, acc_in changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE and clear temp, acc_out, branch to 0; done, err, acc_we, read_data, write_data SHALL be 0 the following cycle.
REQ-031 reset during READ or WRITE SHALL abort; no bank write SHALL occur on any edge where reset=1 or after it for the aborted op; no done pulse for aborted op.
REQ-032 reset and start together SHALL discard start.

Verification
REQ-040 Bank R3=8'h5A, XCH A,R3 with acc_in=8'hC4 -> done 3 cycles later, acc_out=8'h5A, acc_we=1, R3=8'hC4.
REQ-041 R7=8'hFF, INC R7 -> R7=8'h00, acc_we=0, branch=0; then DEC R7 -> R7=8'hFF.
REQ-042 R0=8'h01, DJNZ R0 -> R0=8'h00, branch=0; repeat -> R0=8'hFF, branch=1.
REQ-043 opcode 3'b111 -> done+err 1 cycle after accept, read_data/write_data never high, bank unchanged.
REQ-044 start held high continuously with MOV Rn,A -> operations every 3 cycles, ready low during WRITE/DONE, no extra writes.
REQ-045 reset asserted in READ cycle of INC R2 (R2=8'h10) -> R2 stays 8'h10, no done, ready=1 next cycle, acc_out=0.
